// File: rtl/ir_line_pos.sv
// IR line-position sensor: snapshots eight decay times, thresholds them serially,
// then divides the weighted sum by the hit count. Optional calibration: IR_LINE_CAL_EN.
module ir_line_pos #(
    parameter int NCH = 8,
    parameter int TW  = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [TW-1:0]  ttd0,
    input  logic [TW-1:0]  ttd1,
    input  logic [TW-1:0]  ttd2,
    input  logic [TW-1:0]  ttd3,
    input  logic [TW-1:0]  ttd4,
    input  logic [TW-1:0]  ttd5,
    input  logic [TW-1:0]  ttd6,
    input  logic [TW-1:0]  ttd7,
    input  logic [TW-1:0]  threshold,
`ifdef IR_LINE_CAL_EN
    input  logic           cal_mode,
`endif
    output logic [NCH-1:0] line_bits,
    output logic [7:0]     position,
    output logic           line_lost,
    output logic           valid,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DIV, DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic signed [5:0]    sum_q, sum_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [NCH-1:0]       bits_q, bits_d;
    logic [10:0]          rem_q, rem_d;
    logic [10:0]          dvs_q, dvs_d;
    logic [7:0]           quo_q, quo_d;
    logic [NCH-1:0]       line_bits_q, line_bits_d;
    logic [7:0]           position_q, position_d;
    logic                 lost_q, lost_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic [TW-1:0]        snap_q [NCH];
    logic [TW-1:0]        ttd_s [NCH];
    logic                 load_s;
    logic [TW-1:0]        thr_s;
    logic                 hit_s;
    logic signed [5:0]    w_s;
    logic signed [5:0]    sum_acc_s;
    logic [3:0]           cnt_acc_s;
    logic [5:0]           abs_s;
    logic                 ge_s;
    logic [7:0]           quo_nx_s;

    assign ttd_s[0] = ttd0;
    assign ttd_s[1] = ttd1;
    assign ttd_s[2] = ttd2;
    assign ttd_s[3] = ttd3;
    assign ttd_s[4] = ttd4;
    assign ttd_s[5] = ttd5;
    assign ttd_s[6] = ttd6;
    assign ttd_s[7] = ttd7;

`ifdef IR_LINE_CAL_EN
    logic [TW-1:0]  min_q [NCH];
    logic [TW-1:0]  max_q [NCH];
    logic [NCH-1:0] seen_q;
    logic [TW:0]    mid_sum_s;

    assign mid_sum_s = {1'b0, min_q[idx_q]} + {1'b0, max_q[idx_q]};
    assign thr_s     = seen_q[idx_q] ? mid_sum_s[TW:1] : threshold;

    // Per-channel min/max tracking while calibrating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                min_q[i] <= {TW{1'b1}};
                max_q[i] <= {TW{1'b0}};
            end
            seen_q <= {NCH{1'b0}};
        end else if ((state_q == SCAN) && cal_mode) begin
            if (snap_q[idx_q] < min_q[idx_q]) min_q[idx_q] <= snap_q[idx_q];
            if (snap_q[idx_q] > max_q[idx_q]) max_q[idx_q] <= snap_q[idx_q];
            seen_q[idx_q] <= 1'b1;
        end
    end
`else
    assign thr_s = threshold;
`endif

    // Channel weight is 2*idx-7, giving -7..+7 in steps of two
    assign hit_s     = (snap_q[idx_q] >= thr_s);
    assign w_s       = $signed({2'b00, idx_q, 1'b0}) - 6'sd7;
    assign sum_acc_s = hit_s ? (sum_q + w_s) : sum_q;
    assign cnt_acc_s = hit_s ? (cnt_q + 4'd1) : cnt_q;
    assign abs_s     = sum_acc_s[5] ? (6'd0 - sum_acc_s) : sum_acc_s;
    assign ge_s      = (rem_q >= dvs_q);
    assign quo_nx_s  = {quo_q[6:0], ge_s};

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        bits_d      = bits_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        line_bits_d = line_bits_q;
        position_d  = position_q;
        lost_d      = lost_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        load_s      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_d = SCAN;
                    idx_d   = 3'd0;
                    sum_d   = 6'sd0;
                    cnt_d   = 4'd0;
                    bits_d  = {NCH{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            SCAN: begin
                bits_d[idx_q] = hit_s;
                sum_d         = sum_acc_s;
                cnt_d         = cnt_acc_s;
                idx_d         = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = DIV;
                    rem_d   = {1'b0, abs_s, 4'b0000};
                    dvs_d   = {cnt_acc_s, 7'b0000000};
                    quo_d   = 8'd0;
                end else begin
                    state_d = SCAN;
                end
            end
            DIV: begin
                // Restoring step: divisor starts at count<<7 and walks down one bit per cycle
                rem_d = ge_s ? (rem_q - dvs_q) : rem_q;
                dvs_d = {1'b0, dvs_q[10:1]};
                quo_d = quo_nx_s;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    if (cnt_q == 4'd0) begin
                        lost_d      = 1'b1;
                        line_bits_d = {NCH{1'b0}};
                    end else begin
                        lost_d      = 1'b0;
                        line_bits_d = bits_q;
                        position_d  = sum_q[5] ? (8'd0 - quo_nx_s) : quo_nx_s;
                    end
                end else begin
                    state_d = DIV;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            sum_q       <= 6'sd0;
            cnt_q       <= 4'd0;
            bits_q      <= {NCH{1'b0}};
            rem_q       <= 11'd0;
            dvs_q       <= 11'd0;
            quo_q       <= 8'd0;
            line_bits_q <= {NCH{1'b0}};
            position_q  <= 8'd0;
            lost_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            bits_q      <= bits_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            line_bits_q <= line_bits_d;
            position_q  <= position_d;
            lost_q      <= lost_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    // Input snapshot taken on the accepting edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) snap_q[i] <= {TW{1'b0}};
        end else if (load_s) begin
            for (int i = 0; i < NCH; i++) snap_q[i] <= ttd_s[i];
        end
    end

    assign line_bits = line_bits_q;
    assign position  = position_q;
    assign line_lost = lost_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ir_line_pos.sv
// Self-checking bench for ir_line_pos: directed cases plus randomized measurements
// checked against an arithmetic reference model.
module tb_ir_line_pos;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [16:0] ttd [8];
    logic [16:0] threshold;
    logic [7:0]  line_bits;
    logic [7:0]  position;
    logic        line_lost;
    logic        valid;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    int          m_pos = 0;
    logic [7:0]  e_bits;
    int          e_pos;
    logic        e_lost;

    always #5 clk = ~clk;

    ir_line_pos dut (
        .clk(clk), .rst(rst), .start(start),
        .ttd0(ttd[0]), .ttd1(ttd[1]), .ttd2(ttd[2]), .ttd3(ttd[3]),
        .ttd4(ttd[4]), .ttd5(ttd[5]), .ttd6(ttd[6]), .ttd7(ttd[7]),
        .threshold(threshold),
`ifdef IR_LINE_CAL_EN
        .cal_mode(1'b0),
`endif
        .line_bits(line_bits), .position(position), .line_lost(line_lost),
        .valid(valid), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: bits from threshold, position = trunc(sum*16/count), held when nothing seen
    task automatic model_calc();
        int s;
        int c;
        s = 0;
        c = 0;
        e_bits = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (ttd[i] >= threshold) begin
                e_bits[i] = 1'b1;
                s += 2 * i - 7;
                c++;
            end
        end
        if (c == 0) begin
            e_lost = 1'b1;
            e_bits = 8'h00;
            e_pos  = m_pos;
        end else begin
            e_lost = 1'b0;
            e_pos  = (s * 16) / c;
            m_pos  = e_pos;
        end
    endtask

    task automatic set_mask(input logic [7:0] mask, input logic [16:0] hi, input logic [16:0] lo);
        for (int i = 0; i < 8; i++) ttd[i] = mask[i] ? hi : lo;
    endtask

    task automatic check_out(input string tag, input logic [7:0] b, input int p, input logic l);
        logic [7:0] p8;
        p8 = p[7:0];
        check({tag, "_bits"}, {24'd0, line_bits}, {24'd0, b});
        check({tag, "_pos"}, {24'd0, position}, {24'd0, p8});
        check({tag, "_lost"}, {31'd0, line_lost}, {31'd0, l});
    endtask

    // Called at a negedge with the DUT idle; leaves at the negedge after the valid cycle
    task automatic run_meas(input string tag);
        int n;
        model_calc();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, 32'd16);
        check_out(tag, e_bits, e_pos, e_lost);
        @(negedge clk);
        check({tag, "_vpulse"}, {31'd0, valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] a_bits;
        int         a_pos;
        logic       a_lost;
        logic [7:0] b_bits;
        int         b_pos;
        logic       b_lost;
        int         vcnt;
        int         n;
        int         saw;

        rst = 1'b0;
        start = 1'b0;
        threshold = 17'd1000;
        set_mask(8'h00, 17'd0, 17'd0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check_out("rst", 8'h00, 0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        set_mask(8'h18, 17'd2000, 17'd500); run_meas("center");
        set_mask(8'h01, 17'd2000, 17'd500); run_meas("left112");
        set_mask(8'hC0, 17'd2000, 17'd500); run_meas("right96");
        set_mask(8'h20, 17'd2000, 17'd500); run_meas("p48");
        set_mask(8'h0E, 17'd2000, 17'd500); run_meas("m48");
        set_mask(8'h20, 17'd2000, 17'd500); run_meas("p48b");
        set_mask(8'h00, 17'd2000, 17'd100); run_meas("lost");
        set_mask(8'hFF, 17'd1000, 17'd0);   run_meas("all_eq_thr");

        // start held for 40 cycles; inputs change right after the first accept
        set_mask(8'h18, 17'd2000, 17'd500);
        model_calc();
        a_bits = e_bits; a_pos = e_pos; a_lost = e_lost;
        b_bits = 8'h00; b_pos = 0; b_lost = 1'b0;
        start = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                set_mask(8'h03, 17'd2000, 17'd500);
                model_calc();
                b_bits = e_bits; b_pos = e_pos; b_lost = e_lost;
            end
            if (valid === 1'b1) begin
                vcnt++;
                if (vcnt == 1) begin
                    check("held_v1_cycle", c, 32'd16);
                    check_out("held_v1", a_bits, a_pos, a_lost);
                end else if (vcnt == 2) begin
                    check("held_v2_cycle", c, 32'd33);
                    check_out("held_v2", b_bits, b_pos, b_lost);
                end
            end
        end
        start = 1'b0;
        check("held_vcount", vcnt, 32'd2);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("held_drain", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // reset in the middle of a measurement
        set_mask(8'h81, 17'd2000, 17'd500);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw = 0;
        repeat (9) begin
            @(negedge clk);
            if (valid === 1'b1) saw = 1;
        end
        rst = 1'b1;
        #1;
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check_out("abort", 8'h00, 0, 1'b0);
        check("abort_early_valid", saw, 32'd0);
        m_pos = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_mask(8'h00, 17'd2000, 17'd100);
        run_meas("post_rst_lost");
        set_mask(8'h60, 17'd2000, 17'd500);
        run_meas("post_rst");

        for (int k = 0; k < 24; k++) begin
            threshold = 17'($urandom_range(1, 131071));
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 3))
                    0:       ttd[i] = threshold;
                    1:       ttd[i] = threshold - 17'd1;
                    default: ttd[i] = 17'($urandom_range(0, 131071));
                endcase
            end
            run_meas($sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_line_pos.md
IR_LINE_POS -- requirements
Module: ir_line_pos

Interface
REQ-001 SHALL have parameter NCH, default 8, number of IR channels; only NCH=8 is supported.
REQ-002 SHALL have parameter TW, default 17, width of each time-to-decay value.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle request to take a new measurement.
REQ-006 SHALL have ports ttd0..ttd7, input, 17 each, per-channel decay times from the IR reader.
REQ-007 SHALL have port threshold, input, 17; a ttd value greater than or equal to this means the channel sees the line.
REQ-008 SHALL have port line_bits, output, 8; bit i is the line-detect result for channel i.
REQ-009 SHALL have port position, output, 8, signed line position; negative means toward ch0.
REQ-010 SHALL have port line_lost, output, 1; high when no channel detected the line.
REQ-011 SHALL have port valid, output, 1, a one-cycle result strobe.
REQ-012 SHALL have port busy, output, 1; high while a measurement is in progress.

Function
REQ-013 SHALL implement the states IDLE, SCAN, DIV and DONE.
REQ-014 In IDLE, start=1 SHALL be accepted at that edge (E0): all ttd0..7 are snapshotted, busy goes to 1, state goes to SCAN with idx=0.
REQ-015 start SHALL be ignored whenever busy=1; no queuing.
REQ-016 SCAN SHALL process one channel per cycle over 8 cycles, idx 0..7, as follows:
  - bit_i = (snap_i >= threshold), unsigned compare;
  - when bit_i=1, add weight w_i to a signed sum and increment a 4-bit count;
  - w = {-7,-5,-3,-1,+1,+3,+5,+7} for channels 0..7.
REQ-017 State SHALL go to DIV at E8.
REQ-018 DIV SHALL compute position = trunc((sum*16)/count) with 8 restoring-division iterations, one per cycle.
REQ-019 The division SHALL be done on the magnitude, and the sign SHALL be applied afterwards, so the result truncates toward zero.
REQ-020 position SHALL lie in the range -112..+112.
REQ-021 State SHALL go to DONE at E16.
REQ-022 At E16, line_bits, position and line_lost SHALL update, and valid SHALL be 1 for exactly the cycle E16-E17; at E17 state goes to IDLE and busy to 0.
REQ-023 Total latency SHALL be fixed at 16 cycles from accepting edge to valid, whatever the data.
REQ-024 When count=0, SHALL set line_lost=1, hold position at its previous value, set line_bits=0 and still assert valid at E16.
REQ-025 A new start SHALL be accepted no earlier than E17, so back-to-back throughput is one measurement per 17 cycles.
REQ-026 ttd inputs changing after E0 SHALL NOT affect the result in progress.
REQ-027 threshold SHALL be sampled per SCAN cycle and SHALL be held stable by the user while busy.
REQ-028 Outputs SHALL change only at E16 of a measurement, or at reset.

Reset
REQ-029 rst=1 SHALL asynchronously force:
  - state to IDLE;
  - busy=0, valid=0, line_bits=0, position=0, line_lost=0;
  - sum, count, idx and the snapshot registers to 0.
REQ-030 rst asserted mid-measurement SHALL abort the measurement with no valid pulse; start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-031 With macro IR_LINE_CAL_EN defined, SHALL add input cal_mode (1 bit) and per-channel 17-bit min/max registers, with these rules:
  - while cal_mode=1, each SCAN cycle updates min_i/max_i from snap_i;
  - bit_i compares against (min_i+max_i)>>1 instead of threshold;
  - until both values exist for a channel, threshold is used for it;
  - rst sets min_i=all-ones and max_i=0.
REQ-032 Without IR_LINE_CAL_EN, SHALL have no cal_mode port and no calibration registers, and SHALL compare against the global threshold only.

Verification
REQ-033 Bench SHALL cover: threshold=1000, ttd3=ttd4=2000, others 500, start -> valid 16 cycles later, line_bits=0x18, position=0, line_lost=0.
REQ-034 Bench SHALL cover: ttd0=2000 only -> line_bits=0x01, position=-112; then ttd6=ttd7=2000 only -> position=+96.
REQ-035 Bench SHALL cover: ttd5=2000 only (sum=+3, count=1) -> position=+48; then ttd1=ttd2=ttd3=2000 (sum=-9, count=3) -> position=-48.
REQ-036 Bench SHALL cover: all ttd=100 after a prior result of +48 -> line_lost=1, line_bits=0, position stays +48, valid pulses.
REQ-037 Bench SHALL cover: start held high for 40 cycles -> valid at cycles 16 and 33 only, and ttd changed at E1 does not alter the first result.
REQ-038 Bench SHALL cover: rst pulsed at cycle 9 of a measurement -> no valid, all outputs 0; start 1 cycle after release -> normal result at +16.
